// File: rtl/conv_window_gen_pkg.sv
// Shared defaults and helpers for the convolution window datapath.
// Used by conv_window_gen and line_buffer.
package cnn_pkg;

    localparam int PIXEL_WIDTH_DEF = 8;
    localparam int KERNEL_SIZE_DEF = 4;

    // Counter width that stays at least 1 bit for degenerate depths
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int win_idx(input int r, input int c,
                                   input int k  = KERNEL_SIZE_DEF,
                                   input int pw = PIXEL_WIDTH_DEF);
        return pw * (r * k + c);
    endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out bundle between a raster source and conv_window_gen.
// window_count only exists when WINDOW_COUNT_EN is defined.
interface conv_window_gen_if
    import cnn_pkg::*;
#(
    parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF,
    parameter int KERNEL_SIZE = KERNEL_SIZE_DEF
);
    logic [PIXEL_WIDTH-1:0]                         pixel_in;
    logic                                           pixel_valid;
    logic [PIXEL_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] window_out;
    logic                                           window_valid;
    logic                                           frame_done;
`ifdef WINDOW_COUNT_EN
    logic [15:0]                                    window_count;

    modport master (output pixel_in, pixel_valid,
                    input  window_out, window_valid, frame_done, window_count);
    modport slave  (input  pixel_in, pixel_valid,
                    output window_out, window_valid, frame_done, window_count);
`else
    modport master (output pixel_in, pixel_valid,
                    input  window_out, window_valid, frame_done);
    modport slave  (input  pixel_in, pixel_valid,
                    output window_out, window_valid, frame_done);
`endif
endinterface

// File: rtl/conv_window_gen_line_buffer.sv
// One-row delay: circular RAM of DEPTH entries advancing only on en.
// dout is the entry written DEPTH accepted samples ago (read-before-write).
module line_buffer
    import cnn_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    localparam int            AW   = cw(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    ptr;

    assign dout = mem[ptr];

    always_ff @(posedge clock) begin
        if (reset)
            ptr <= '0;
        else if (en)
            ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
    end

    // Contents are never cleared; row/col gating upstream masks stale rows
    always_ff @(posedge clock) begin
        if (en)
            mem[ptr] <= din;
    end

endmodule

// File: rtl/conv_window_gen.sv
// KxK stride-1 sliding-window generator over a raster pixel stream, 1-cycle latency.
// Define WINDOW_COUNT_EN to add the saturating per-frame window_count output.
module conv_window_gen
    import cnn_pkg::*;
#(
    parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF,
    parameter int KERNEL_SIZE = KERNEL_SIZE_DEF,
    parameter int IMG_WIDTH   = 32,
    parameter int IMG_HEIGHT  = 32
) (
    input  logic             clock,
    input  logic             reset,
    conv_window_gen_if.slave pix
);
    localparam int K  = KERNEL_SIZE;
    localparam int PW = PIXEL_WIDTH;
    localparam int CW = cw(IMG_WIDTH);
    localparam int RW = cw(IMG_HEIGHT);

    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    // tap[i] = pixel i rows above the incoming one, same column
    logic [K-1:0][PW-1:0]        tap;
    logic [K-1:0][K-1:0][PW-1:0] win;
    logic [PW*K*K-1:0]           flat;
    logic                        win_d, done_d;

    assign tap[0] = pix.pixel_in;

    for (genvar i = 1; i < K; i++) begin : g_lb
        line_buffer #(.WIDTH(PW), .DEPTH(IMG_WIDTH)) u_lb (
            .clock (clock),
            .reset (reset),
            .en    (pix.pixel_valid),
            .din   (tap[i-1]),
            .dout  (tap[i])
        );
    end

    assign win_d  = pix.pixel_valid && (row >= ROW_FIRST) && (col >= COL_FIRST);
    assign done_d = pix.pixel_valid && (row == ROW_LAST) && (col == COL_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (pix.pixel_valid) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Row 0 is the oldest line, so it is fed from the deepest tap
    always_ff @(posedge clock) begin
        if (reset) begin
            win <= '0;
        end else if (pix.pixel_valid) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++)
                    win[r][c] <= win[r][c+1];
                win[r][K-1] <= tap[K-1-r];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pix.window_valid <= 1'b0;
            pix.frame_done   <= 1'b0;
        end else begin
            pix.window_valid <= win_d;
            pix.frame_done   <= done_d;
        end
    end

    always_comb begin
        flat = '0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                flat[win_idx(r, c, K, PW) +: PW] = win[r][c];
    end

    assign pix.window_out = flat;

`ifdef WINDOW_COUNT_EN
    logic [15:0] wcnt;

    // Holds the frame total during the frame_done cycle, then restarts
    always_ff @(posedge clock) begin
        if (reset)
            wcnt <= '0;
        else if (pix.frame_done)
            wcnt <= {15'd0, win_d};
        else if (win_d && wcnt != 16'hFFFF)
            wcnt <= wcnt + 16'd1;
    end

    assign pix.window_count = wcnt;
`endif

endmodule
